// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op width and op encoding.
package pc_seq_pkg;

    localparam int OP_W = 3;

    // Opcodes issued by the control FSM, one per cycle. Values 6 and 7 are reserved.
    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack: register array addressed by a depth pointer.
// Only the pointer is reset; entry contents are don't-care until pushed.
module pc_ret_stack #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            din,
    output logic [ADDR_W-1:0]            dout,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [DW-1:0]     depth_q;
    logic [DW-1:0]     depth_d;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     rd_idx;

    // Next free slot is the low bits of depth; the top entry sits one below it
    // (modulo the array size, which also covers the full case).
    assign wr_idx = depth_q[PW-1:0];
    assign rd_idx = wr_idx - PW'(1);

    assign dout  = mem_q[rd_idx];
    assign depth = depth_q;
    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    // Pointer update; the caller never asserts push and pop together.
    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Depth pointer register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage, written on a non-full push.
    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: op decode, next-PC mux, return stack and sticky
// stack/opcode fault flags. pc_next exposes the value pc takes at the next edge.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 6,
    parameter int                OFF_W       = 6,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [OP_W-1:0]              op,
    input  logic [ADDR_W-1:0]            target,
    input  logic [OFF_W-1:0]             offset,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_next,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         ill_err
);

    logic [ADDR_W-1:0]       pc_q;
    logic [ADDR_W-1:0]       pc_d;
    logic                    ovf_q, unf_q, ill_q;
    logic                    ovf_set, unf_set, ill_set;
    logic                    push, pop;
    logic [ADDR_W-1:0]       pc_inc;
    logic [ADDR_W-1:0]       off_ext;
    logic signed [OFF_W-1:0] offset_s;
    logic [ADDR_W-1:0]       stk_top;
    logic                    stk_full, stk_empty;

    // All PC arithmetic wraps modulo 2^ADDR_W; the offset is sign-extended first.
    assign offset_s = offset;
    assign off_ext  = ADDR_W'(offset_s);
    assign pc_inc   = pc_q + ADDR_W'(1);

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Op decode and next-PC selection; reset beats stall beats op.
    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        ill_set = 1'b0;
        if (reset) begin
            pc_d = RESET_VEC;
        end else if (!stall) begin
            case (op_e'(op))
                OP_HOLD:   pc_d = pc_q;
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = target;
                OP_BRANCH: pc_d = pc_q + off_ext;
                OP_CALL: begin
                    if (stk_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                default:   ill_set = 1'b1;
            endcase
        end
    end

    // PC register; reset value is already folded into pc_d.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // Sticky fault flags: clr_err clears, but a same-cycle new event keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_err) | ovf_set;
            unf_q <= (unf_q & ~clr_err) | unf_set;
            ill_q <= (ill_q & ~clr_err) | ill_set;
        end
    end

    assign pc          = pc_q;
    assign pc_next     = pc_d;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign ill_err     = ill_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios followed by random ops, all checked
// against a queue-based reference model of the sequencer.
module tb_pc_seq;

    localparam int ADDR_W      = 6;
    localparam int OFF_W       = 6;
    localparam int STACK_DEPTH = 4;
    localparam int DW          = $clog2(STACK_DEPTH) + 1;
    localparam int MODV        = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_VEC = '0;

    logic              clk = 1'b0;
    logic              reset, stall, clr_err;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [DW-1:0]     depth;
    logic              stack_full, stack_empty, ovf_err, unf_err, ill_err;

    pc_seq #(
        .ADDR_W      (ADDR_W),
        .OFF_W       (OFF_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_VEC   (RESET_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .clr_err     (clr_err),
        .pc          (pc),
        .pc_next     (pc_next),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err),
        .ill_err     (ill_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf, m_ill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the current inputs.
    task automatic model_edge();
        int off;
        if (reset) begin
            m_pc = RESET_VEC;
            m_stk.delete();
            m_ovf = 0; m_unf = 0; m_ill = 0;
            return;
        end
        if (clr_err) begin
            m_ovf = 0; m_unf = 0; m_ill = 0;
        end
        if (stall) return;
        case (op)
            3'd0: ;
            3'd1: m_pc = (m_pc + 1) % MODV;
            3'd2: m_pc = target;
            3'd3: begin
                off  = $signed(offset);
                m_pc = (((m_pc + off) % MODV) + MODV) % MODV;
            end
            3'd4: begin
                if (m_stk.size() == STACK_DEPTH) m_ovf = 1;
                else begin
                    m_stk.push_back((m_pc + 1) % MODV);
                    m_pc = target;
                end
            end
            3'd5: begin
                if (m_stk.size() == 0) m_unf = 1;
                else m_pc = m_stk.pop_back();
            end
            default: m_ill = 1;
        endcase
    endtask

    // Inputs are already applied (just after a rising edge). Check pc_next,
    // take the edge, then check all registered outputs.
    task automatic cycle(input string tag);
        model_edge();
        #1;
        chk({tag, ".pc_next"}, 32'(pc_next), 32'(m_pc));
        @(posedge clk);
        #1;
        chk({tag, ".pc"},     32'(pc),          32'(m_pc));
        chk({tag, ".depth"},  32'(depth),       32'(m_stk.size()));
        chk({tag, ".full"},   32'(stack_full),  32'(m_stk.size() == STACK_DEPTH));
        chk({tag, ".empty"},  32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".ovf"},    32'(ovf_err),     32'(m_ovf));
        chk({tag, ".unf"},    32'(unf_err),     32'(m_unf));
        chk({tag, ".ill"},    32'(ill_err),     32'(m_ill));
    endtask

    task automatic drive(input string tag, input bit r, input bit s, input int o,
                         input int tgt, input int ofs, input bit c);
        reset   = r;
        stall   = s;
        op      = 3'(o);
        target  = ADDR_W'(tgt);
        offset  = OFF_W'(ofs);
        clr_err = c;
        cycle(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; op = '0; target = '0; offset = '0; clr_err = 1'b0;
        m_pc = 0;
        @(posedge clk); #1;

        // 1. reset, INC x3, wrap at 63, HOLD
        drive("rst", 1, 0, 0, 0, 0, 0);
        chk("rst.pc_const", 32'(pc), 32'd0);
        for (int i = 0; i < 3; i++) drive("inc", 0, 0, 1, 0, 0, 0);
        chk("inc3.pc_const", 32'(pc), 32'd3);
        drive("jmp63", 0, 0, 2, 63, 0, 0);
        drive("incwrap", 0, 0, 1, 0, 0, 0);
        chk("incwrap.pc_const", 32'(pc), 32'd0);
        drive("hold", 0, 0, 0, 0, 0, 0);

        // 2. JUMP and BRANCH wrap in both directions
        drive("jmp10", 0, 0, 2, 10, 0, 0);
        drive("brneg", 0, 0, 3, 0, 6'b110100, 0);
        chk("brneg.pc_const", 32'(pc), 32'd62);
        drive("brpos", 0, 0, 3, 0, 5, 0);
        chk("brpos.pc_const", 32'(pc), 32'd3);
        drive("br0", 0, 0, 3, 0, 0, 0);

        // 3. nested calls return in reverse order
        drive("jmp5", 0, 0, 2, 5, 0, 0);
        drive("call20", 0, 0, 4, 20, 0, 0);
        drive("call40", 0, 0, 4, 40, 0, 0);
        drive("ret1", 0, 0, 5, 0, 0, 0);
        chk("ret1.pc_const", 32'(pc), 32'd21);
        drive("ret2", 0, 0, 5, 0, 0, 0);
        chk("ret2.pc_const", 32'(pc), 32'd6);

        // 4. overflow, underflow, clear
        for (int i = 0; i < 5; i++) drive("callN", 0, 0, 4, 8 * (i + 1), 0, 0);
        chk("ovf.flag_const", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 5; i++) drive("retN", 0, 0, 5, 0, 0, 0);
        chk("unf.flag_const", 32'(unf_err), 32'd1);
        drive("clr", 0, 0, 0, 0, 0, 1);

        // 5. stall freezes everything; set beats clear
        drive("call9", 0, 0, 4, 9, 0, 0);
        drive("stallcall", 0, 1, 4, 33, 0, 0);
        drive("stallret", 0, 1, 5, 0, 0, 0);
        drive("ret9", 0, 0, 5, 0, 0, 0);
        drive("clr_vs_unf", 0, 0, 5, 0, 0, 1);
        drive("stall_ill", 0, 1, 7, 0, 0, 0);
        drive("stall_clr", 0, 1, 0, 0, 0, 1);

        // 6. reset mid-sequence, reserved ops
        for (int i = 0; i < 3; i++) drive("call3", 0, 0, 4, 12 + i, 0, 0);
        drive("rst_ret", 1, 0, 5, 0, 0, 0);
        chk("rst_ret.depth_const", 32'(depth), 32'd0);
        drive("inc_after", 0, 0, 1, 0, 0, 0);
        drive("op7", 0, 0, 7, 0, 0, 0);
        drive("op6", 0, 0, 6, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bit r, s, c;
            int o;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 9) == 0);
            o = (n % 40 < 20) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 7));
            drive("rand", r, s, o, int'($urandom_range(0, MODV - 1)),
                  int'($urandom_range(0, (1 << OFF_W) - 1)), c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program-counter sequencer for the 8-bit core. It generalises the basic load/increment PC into a clocked unit with these features:
- absolute jump and PC-relative branch
- call/return through an internal hardware return-address stack
- stall
- sticky stack-fault flags

It sits between the control FSM, which issues one op per cycle, and the instruction-memory address bus.

Parameters:
- ADDR_W, 6, PC / address width in bits.
- OFF_W, 6, signed branch-offset width (two's complement, OFF_W <= ADDR_W).
- STACK_DEPTH, 4, return-stack entries (power of two, >= 2).
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  freeze PC and stack; op ignored this cycle.
- op  in  3  0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 reserved.
- target  in  ADDR_W  absolute address for JUMP/CALL.
- offset  in  OFF_W  signed displacement for BRANCH.
- clr_err  in  1  clears sticky error flags.
- pc  out  ADDR_W  current fetch address (registered).
- pc_next  out  ADDR_W  combinational value pc will take at the next edge.
- depth  out  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- ovf_err  out  1  sticky: CALL attempted while full.
- unf_err  out  1  sticky: RET attempted while empty.
- ill_err  out  1  sticky: reserved opcode seen (when not stalled).

Behaviour:
- Reset: synchronous, active-high.
  - pc = RESET_VEC, depth = 0, all error flags = 0, stack contents don't-care.
- Priority per edge: reset > stall > op > clr_err.
  - clr_err and a new error event in the same cycle: the flag ends set (set wins).
- Latency: op sampled at edge N; pc reflects the result after edge N.
  - pc_next always equals that post-edge value: RESET_VEC if reset, pc if stall.
- Width rule: all PC arithmetic is modulo 2^ADDR_W, with no carry out.
- HOLD: pc unchanged.
- INC: pc <= pc + 1. 2^ADDR_W-1 wraps to 0.
- JUMP: pc <= target.
- BRANCH: pc <= pc + sign_extend(offset), wrapping both directions.
  - offset = 0 leaves pc unchanged.
- CALL, not full:
  - push (pc + 1) mod 2^ADDR_W, depth += 1, pc <= target.
- CALL, full:
  - no push, pc and depth unchanged, ovf_err <= 1.
- RET, not empty:
  - pc <= top entry, depth -= 1.
- RET, empty:
  - pc and depth unchanged, unf_err <= 1.
- Reserved op (6/7):
  - treated as HOLD, ill_err <= 1.
- Stall: pc, depth and stack frozen; no error flags set.
  - clr_err is still honoured during stall.
- Stack: LIFO, push and pop never occur in the same cycle (one op per cycle).
- Nested CALLs up to STACK_DEPTH deep must return in exact reverse order.
- Reset mid-sequence (e.g. stack partly full) discards all entries.

Decomposition:
- Shared package pc_seq_pkg:
  - op encoding constants (OP_HOLD..OP_RET)
  - localparam for the op width (3)
- One sub-module, pc_ret_stack, with ports:
  - clk, reset, push, pop, din, dout (top of stack), depth, full, empty
- Parameters of pc_ret_stack: ADDR_W, STACK_DEPTH.
- It implements register-array storage with a depth pointer. pc_seq owns the op decode, next-PC mux and error flags.

Test Plan:
1. Reset, INC x3, then pc=63, INC, HOLD (defaults):
   - reset -> pc=0; after INC x3 -> pc=3.
   - pc=63 with INC -> pc=0; HOLD -> pc stays 0.
2. JUMP and BRANCH wrap:
   - JUMP target=10 -> pc=10.
   - BRANCH offset=-12 (6'b110100) -> pc=62.
   - BRANCH offset=+5 -> pc=3.
3. Nested calls:
   - pc=5, CALL 20 -> pc=20, depth=1.
   - CALL 40 -> pc=40, depth=2.
   - RET -> pc=21; RET -> pc=6, depth=0, stack_empty=1.
4. Overflow/underflow:
   - 4 CALLs -> stack_full=1; 5th CALL -> pc unchanged, ovf_err=1.
   - Drain with 4 RETs, then 5th RET -> unf_err=1, pc unchanged.
   - clr_err -> both flags 0.
5. Stall and simultaneity:
   - stall=1 with op=CALL -> pc and depth unchanged, pc_next=pc.
   - clr_err with RET-on-empty in the same cycle -> unf_err=1.
6. Reset mid-operation and reserved op:
   - depth=3, reset with op=RET -> pc=RESET_VEC, depth=0.
   - op=7 -> ill_err=1, pc held.
